snake_head_mover: RTL

Consumer end of the direction interface: samples the 2-bit `dir` code from the button handler on each game tick, advances the snake head one grid cell, and detects wall and body collisions. Drives `gameOver` back to the button handler, which forces the direction to up while it is high. Sits between the button handler and the body/grid store and VGA renderer.

---
 rtl/snake_head_mover_pkg.sv | 22 ++
 rtl/snake_head_mover_if.sv | 31 +++
 rtl/snake_head_mover_game_tick_gen.sv | 31 +++
 rtl/snake_head_mover.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/snake_head_mover_pkg.sv
// rtl/snake_head_mover_pkg.sv - shared direction codes, FSM encoding and default grid sizes
package snake_pkg;

   // Direction codes as delivered by the button handler
   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   // Game FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   // Default playfield and tick rate (10 Hz at 100 MHz)
   localparam int DEF_GRID_W   = 40;
   localparam int DEF_GRID_H   = 30;
   localparam int DEF_TICK_DIV = 10_000_000;

endpackage

// File: rtl/snake_head_mover_if.sv
// rtl/snake_head_mover_if.sv - direction/head bus between button handler, head mover and body store
interface snake_head_mover_if
   import snake_pkg::*;
#(
   parameter int GRID_W = DEF_GRID_W,
   parameter int GRID_H = DEF_GRID_H
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);

   logic [1:0]    dir;
   logic          start;
   logic          collide_body;
   logic [XW-1:0] head_x;
   logic [YW-1:0] head_y;
   logic          step;
   logic          gameOver;

   // Producer side: button handler / body store
   modport master (
      output dir, start, collide_body,
      input  head_x, head_y, step, gameOver
   );

   // Consumer side: the head mover
   modport slave (
      input  dir, start, collide_body,
      output head_x, head_y, step, gameOver
   );

endinterface

// File: rtl/snake_head_mover_game_tick_gen.sv
// rtl/snake_head_mover_game_tick_gen.sv - game tick divider with enable, sync clear and terminal-count pulse
module game_tick_gen
   import snake_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tc
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tc = en && (cnt == CNT_LAST);

   // Count 0..TICK_DIV-1 while enabled; clear wins over counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/snake_head_mover.sv
// rtl/snake_head_mover.sv - snake head stepper with wall/body collision; SNAKE_WRAP_EN selects wrapping walls
module snake_head_mover
   import snake_pkg::*;
#(
   parameter int GRID_W   = DEF_GRID_W,
   parameter int GRID_H   = DEF_GRID_H,
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic               CLK_100MHz,
   input  logic               RST,
   snake_head_mover_if.slave  bus
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam logic [XW-1:0] X_CTR = XW'(GRID_W / 2);
   localparam logic [YW-1:0] Y_CTR = YW'(GRID_H / 2);
   localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

   state_t        state;
   logic [XW-1:0] head_x;
   logic [YW-1:0] head_y;
   logic          step_r;
   logic          game_over_r;
   logic          chk_body;      // high in the one cycle where collide_body is meaningful

   logic [XW-1:0] nxt_x;
   logic [YW-1:0] nxt_y;
   logic          wall_hit;
   logic          body_hit;
   logic          tick;
   logic          cnt_clr;

   assign bus.head_x   = head_x;
   assign bus.head_y   = head_y;
   assign bus.step     = step_r;
   assign bus.gameOver = game_over_r;

   // The body store answers for the new head cell one cycle after step is seen
   assign body_hit = (state == ST_RUN) && chk_body && bus.collide_body;

   // Counter freezes at 0 outside RUN and is cleared on the edge that leaves RUN
   assign cnt_clr = (state != ST_RUN) || body_hit || (tick && wall_hit);

   game_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk (CLK_100MHz),
      .rst (RST),
      .en  (state == ST_RUN),
      .clr (cnt_clr),
      .tc  (tick)
   );

   // Candidate next cell for the current direction, and whether it leaves the grid
   always_comb begin
      nxt_x    = head_x;
      nxt_y    = head_y;
      wall_hit = 1'b0;
      case (bus.dir)
         DIR_UP: begin
            if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
               nxt_y = Y_MAX;
`else
               wall_hit = 1'b1;
`endif
            end else begin
               nxt_y = head_y - YW'(1);
            end
         end
         DIR_RIGHT: begin
            if (head_x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
               nxt_x = '0;
`else
               wall_hit = 1'b1;
`endif
            end else begin
               nxt_x = head_x + XW'(1);
            end
         end
         DIR_DOWN: begin
            if (head_y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
               nxt_y = '0;
`else
               wall_hit = 1'b1;
`endif
            end else begin
               nxt_y = head_y + YW'(1);
            end
         end
         default: begin
            if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
               nxt_x = X_MAX;
`else
               wall_hit = 1'b1;
`endif
            end else begin
               nxt_x = head_x - XW'(1);
            end
         end
      endcase
   end

   // Game FSM with registered head, step and gameOver
   always_ff @(posedge CLK_100MHz or posedge RST) begin
      if (RST) begin
         state       <= ST_IDLE;
         head_x      <= X_CTR;
         head_y      <= Y_CTR;
         step_r      <= 1'b0;
         game_over_r <= 1'b0;
         chk_body    <= 1'b0;
      end else begin
         step_r   <= 1'b0;
         chk_body <= step_r;
         case (state)
            ST_IDLE: begin
               head_x <= X_CTR;
               head_y <= Y_CTR;
               if (bus.start) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (body_hit) begin
                  state       <= ST_OVER;
                  game_over_r <= 1'b1;
               end else if (tick) begin
                  if (wall_hit) begin
                     state       <= ST_OVER;
                     game_over_r <= 1'b1;
                  end else begin
                     head_x <= nxt_x;
                     head_y <= nxt_y;
                     step_r <= 1'b1;
                  end
               end
            end
            ST_OVER: begin
               if (bus.start) begin
                  state       <= ST_RUN;
                  game_over_r <= 1'b0;
                  head_x      <= X_CTR;
                  head_y      <= Y_CTR;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
